csr_exec_unit: RTL and testbench
================================

CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, CSR data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, CSR address width (Zicsr encoding).
REQ-003 SHALL have parameter TICKET_W, default 3, width of the ROB ticket carried with each request.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  pipeline flush; aborts any in-flight request.
REQ-007 SHALL have port req_valid  input  1  CSR instruction valid.
REQ-008 SHALL have port req_ready  output  1  unit can accept a request.
REQ-009 SHALL have port req_op  input  2  operation: 01 RW, 10 RS (set), 11 RC (clear); 00 reserved.
REQ-010 SHALL have port req_use_imm  input  1  source operand is zero-extended zimm instead of rs1 data.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  target CSR address.
REQ-012 SHALL have port req_rs1_data  input  DATA_WIDTH  rs1 operand.
REQ-013 SHALL have port req_zimm  input  5  immediate operand; also the rs1 index for the no-write rule.
REQ-014 SHALL have port req_ticket  input  TICKET_W  ROB ticket.
REQ-015 SHALL have port csr_rd_addr  output  ADDR_WIDTH  read address to the CSR register file.
REQ-016 SHALL have port csr_rd_data  input  DATA_WIDTH  combinational read data from the CSR register file.
REQ-017 SHALL have port csr_wr_en  output  1  single-cycle write strobe.
REQ-018 SHALL have port csr_wr_addr  output  ADDR_WIDTH  write address.
REQ-019 SHALL have port csr_wr_data  output  DATA_WIDTH  write data.
REQ-020 SHALL have port resp_valid  output  1  result available.
REQ-021 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-022 SHALL have port resp_data  output  DATA_WIDTH  old CSR value (written to rd).
REQ-023 SHALL have port resp_ticket  output  TICKET_W  ticket of the completed request.
REQ-024 SHALL have port resp_illegal  output  1  request raised an illegal-instruction exception.

Function
REQ-025 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-026 IDLE: req_ready=1 unless flush=1; a handshake (req_valid&req_ready) SHALL capture all req_* fields and move to READ.
REQ-027 READ: csr_rd_addr = captured address; csr_rd_data SHALL be latched as old value; next state WRITE.
REQ-028 WRITE: new value SHALL be computed as RW src, RS old|src, RC old&~src; src = use_imm ? zero-extended zimm : rs1_data.
REQ-029 WRITE: csr_wr_en SHALL pulse exactly one cycle with wr_addr = captured address, unless the write is suppressed; next state RESP.
REQ-030 Write SHALL be suppressed for RS/RC when zimm==0 (covers both rs1=x0 and immediate 0); RW always writes.
REQ-031 A write attempt to a read-only address (addr[11:10]==2'b11) or req_op==00 SHALL set illegal, suppress the write and force resp_data=0.
REQ-032 RS/RC with zimm==0 to a read-only address SHALL be legal (pure read).
REQ-033 RESP: resp_valid=1 and outputs SHALL hold stable until resp_ready; on resp_valid&resp_ready the FSM SHALL return to IDLE.
REQ-034 Latency: handshake at cycle N -> write strobe at N+2 -> resp_valid from N+3; back-to-back throughput one request per 4 cycles with resp_ready=1.
REQ-035 flush=1 in any state SHALL force IDLE next cycle, csr_wr_en=0 in that cycle, resp_valid=0 next cycle, and no request accepted that cycle.
REQ-036 csr_wr_en SHALL never be asserted outside WRITE.

Reset
REQ-037 On rst_n low the FSM SHALL enter IDLE asynchronously.
REQ-038 During and after reset: resp_valid=0, csr_wr_en=0, resp_illegal=0, resp_data=0, resp_ticket=0, csr_rd_addr=0, csr_wr_addr=0, csr_wr_data=0.
REQ-039 Reset during READ/WRITE/RESP SHALL discard the request with no write issued.

Structure
REQ-040 csr_pkg SHALL hold the csr_op_t enum (RW/RS/RC), the FSM state typedef, read-only address-field constant, and a read-only-check function.
REQ-041 Combinational modify logic SHALL be a sub-module csr_modify (op, old, src -> new, write_needed).

Verification
REQ-042 RW addr 0x300, rs1=0xDEADBEEF, CSR holds 0x11 -> wr_en once at N+2 with data 0xDEADBEEF, resp_data=0x11, illegal=0.
REQ-043 RS use_imm zimm=0x5, CSR holds 0xA0 -> wr_data 0xA5, resp_data 0xA0; RC rs1=0xF0 on 0xA5 -> wr_data 0x05.
REQ-044 RS zimm=0 addr 0xC00 (cycle) holding 0x1234 -> no wr_en, resp_data 0x1234, illegal=0; RW to 0xC00 -> no wr_en, illegal=1, resp_data 0.
REQ-045 resp_ready held low 5 cycles in RESP -> resp_valid, resp_data, resp_ticket stable; req_ready=0 throughout.
REQ-046 flush asserted in WRITE cycle -> no wr_en, IDLE next cycle, no resp_valid; next request completes normally.
REQ-047 rst_n pulsed low in READ -> all outputs to reset values immediately, no write ever issued.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR execution unit: operation encoding,
// FSM state constants and the read-only address check.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    typedef logic [1:0] csr_state_t;

    localparam csr_state_t ST_IDLE  = 2'd0;
    localparam csr_state_t ST_READ  = 2'd1;
    localparam csr_state_t ST_WRITE = 2'd2;
    localparam csr_state_t ST_RESP  = 2'd3;

    // Zicsr: addr[11:10] == 2'b11 marks a read-only CSR.
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    function automatic logic csr_is_read_only(input logic [1:0] addr_hi);
        return addr_hi == CSR_RO_FIELD;
    endfunction

endpackage

// File: rtl/csr_modify.sv
// Combinational read-modify-write datapath: new CSR value and whether the
// instruction architecturally performs a write.
module csr_modify
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  csr_op_t               op_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] src_i,
    input  logic                  zimm_zero_i,
    output logic [DATA_WIDTH-1:0] new_o,
    output logic                  write_needed_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        new_o          = '0;
        write_needed_o = 1'b0;
        case (op_i)
            CSR_OP_RW: begin
                new_o          = src_i;
                write_needed_o = 1'b1;
            end
            // Set/clear with rs1=x0 or zimm=0 is a pure read.
            CSR_OP_RS: begin
                new_o          = old_i | src_i;
                write_needed_o = !zimm_zero_i;
            end
            CSR_OP_RC: begin
                new_o          = old_i & ~src_i;
                write_needed_o = !zimm_zero_i;
            end
            default: begin
                new_o          = '0;
                write_needed_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execution unit: captures one Zicsr instruction, reads the CSR, issues at
// most one write strobe and returns the old value with its ROB ticket.
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int TICKET_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic                  req_use_imm,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_rs1_data,
    input  logic [4:0]            req_zimm,
    input  logic [TICKET_W-1:0]   req_ticket,
    output logic [ADDR_WIDTH-1:0] csr_rd_addr,
    input  logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic                  csr_wr_en,
    output logic [ADDR_WIDTH-1:0] csr_wr_addr,
    output logic [DATA_WIDTH-1:0] csr_wr_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TICKET_W-1:0]   resp_ticket,
    output logic                  resp_illegal
);

    csr_state_t            state_q, state_d;
    csr_op_t               op_q;
    logic                  use_imm_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rs1_q;
    logic [4:0]            zimm_q;
    logic [TICKET_W-1:0]   ticket_q;
    logic [DATA_WIDTH-1:0] old_q;

    logic                  capture;
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  write_needed;
    logic                  illegal;

    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign capture   = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (capture) state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Captured fields are reset too, so every address/data output reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= CSR_OP_NONE;
            use_imm_q <= 1'b0;
            addr_q    <= '0;
            rs1_q     <= '0;
            zimm_q    <= '0;
            ticket_q  <= '0;
            old_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            if (capture) begin
                op_q      <= csr_op_t'(req_op);
                use_imm_q <= req_use_imm;
                addr_q    <= req_addr;
                rs1_q     <= req_rs1_data;
                zimm_q    <= req_zimm;
                ticket_q  <= req_ticket;
            end
            if (state_q == ST_READ) old_q <= csr_rd_data;
        end
    end

    assign src = use_imm_q ? {{(DATA_WIDTH-5){1'b0}}, zimm_q} : rs1_q;

    csr_modify #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_modify (
        .op_i           (op_q),
        .old_i          (old_q),
        .src_i          (src),
        .zimm_zero_i    (zimm_q == 5'd0),
        .new_o          (new_val),
        .write_needed_o (write_needed)
    );

    // A reserved op, or any real write attempt to a read-only CSR, traps.
    assign illegal = (op_q == CSR_OP_NONE) ||
                     (csr_is_read_only(addr_q[ADDR_WIDTH-1 -: 2]) && write_needed);

    assign csr_rd_addr  = addr_q;
    assign csr_wr_addr  = addr_q;
    assign csr_wr_data  = new_val;
    assign csr_wr_en    = (state_q == ST_WRITE) && write_needed && !illegal && !flush;

    assign resp_valid   = (state_q == ST_RESP);
    assign resp_data    = illegal ? '0 : old_q;
    assign resp_ticket  = ticket_q;
    assign resp_illegal = (state_q == ST_RESP) && illegal;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: a behavioural CSR file plus a
// spec-level reference model, exercised by directed and random requests.
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_use_imm = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_rs1_data = '0;
    logic [4:0]  req_zimm = '0;
    logic [2:0]  req_ticket = '0;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [2:0]  resp_ticket;
    logic        resp_illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] csr_mem [0:4095];
    int          wr_count = 0;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    csr_exec_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .TICKET_W(3)) dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op),
        .req_use_imm (req_use_imm), .req_addr (req_addr), .req_rs1_data (req_rs1_data),
        .req_zimm (req_zimm), .req_ticket (req_ticket),
        .csr_rd_addr (csr_rd_addr), .csr_rd_data (csr_rd_data),
        .csr_wr_en (csr_wr_en), .csr_wr_addr (csr_wr_addr), .csr_wr_data (csr_wr_data),
        .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_data (resp_data),
        .resp_ticket (resp_ticket), .resp_illegal (resp_illegal)
    );

    // Behavioural CSR register file: combinational read, clocked write.
    assign csr_rd_data = csr_mem[csr_rd_addr];
    always @(posedge clk) begin
        if (csr_wr_en) begin
            csr_mem[csr_wr_addr] <= csr_wr_data;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            csr_mem[pre_addr] <= pre_data;
        end
    end

    task automatic set_csr(input logic [11:0] addr, input logic [31:0] data);
        pre_addr = addr; pre_data = data; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({resp_valid, csr_wr_en, resp_illegal} !== 3'b000 || resp_data !== 32'h0 ||
            resp_ticket !== 3'h0 || csr_rd_addr !== 12'h0 || csr_wr_addr !== 12'h0 ||
            csr_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL %s: rv=%b we=%b ill=%b rdata=%h tkt=%h rda=%h wra=%h wrd=%h, all required zero",
                     tag, resp_valid, csr_wr_en, resp_illegal, resp_data, resp_ticket,
                     csr_rd_addr, csr_wr_addr, csr_wr_data);
        end
    endtask

    // One complete request against the reference model; hold = cycles resp_ready stays low in RESP.
    task automatic run_req(input logic [1:0] op, input logic use_imm, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic [4:0] zimm, input logic [2:0] ticket,
                           input logic [31:0] init, input int hold, input string tag);
        logic [31:0] src, exp_new, exp_resp;
        logic        exp_ill, exp_we, attempt;
        int          base, n;
        set_csr(addr, init);
        src      = use_imm ? {27'b0, zimm} : rs1;
        attempt  = (op == 2'b01) || (zimm != 5'd0);
        exp_ill  = (op == 2'b00) || ((addr[11:10] == 2'b11) && attempt);
        exp_we   = !exp_ill && attempt;
        exp_new  = (op == 2'b01) ? src : (op == 2'b10) ? (init | src) : (init & ~src);
        exp_resp = exp_ill ? 32'h0 : init;

        req_valid = 1'b1; req_op = op; req_use_imm = use_imm; req_addr = addr;
        req_rs1_data = rs1; req_zimm = zimm; req_ticket = ticket;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (!req_ready) begin
            errors++; $display("FAIL %s req_ready timeout: got 0 required 1", tag);
            req_valid = 1'b0; resp_ready = 1'b1;
            return;
        end
        base = wr_count;
        @(posedge clk); #1;                       // cycle N+1 (READ)
        req_valid = 1'b0;
        checks++;
        if (csr_rd_addr !== addr || csr_wr_en !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s read: rd_addr=%h we=%b rv=%b required %h 0 0",
                               tag, csr_rd_addr, csr_wr_en, resp_valid, addr);
        end
        @(posedge clk); #1;                       // cycle N+2 (WRITE)
        checks++;
        if (csr_wr_en !== exp_we) begin
            errors++; $display("FAIL %s wr_en: got %b required %b", tag, csr_wr_en, exp_we);
        end
        if (exp_we) begin
            checks++;
            if (csr_wr_addr !== addr || csr_wr_data !== exp_new) begin
                errors++; $display("FAIL %s wr: addr=%h data=%h required %h %h",
                                   tag, csr_wr_addr, csr_wr_data, addr, exp_new);
            end
        end
        @(posedge clk); #1;                       // cycle N+3 (RESP)
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_resp || resp_ticket !== ticket ||
            resp_illegal !== exp_ill || req_ready !== 1'b0 || csr_wr_en !== 1'b0) begin
            errors++; $display("FAIL %s resp: rv=%b data=%h tkt=%h ill=%b rr=%b we=%b required 1 %h %h %b 0 0",
                               tag, resp_valid, resp_data, resp_ticket, resp_illegal, req_ready,
                               csr_wr_en, exp_resp, ticket, exp_ill);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_resp || resp_ticket !== ticket ||
                req_ready !== 1'b0) begin
                errors++; $display("FAIL %s hold%0d: rv=%b data=%h tkt=%h rr=%b required 1 %h %h 0",
                                   tag, k, resp_valid, resp_data, resp_ticket, req_ready, exp_resp, ticket);
            end
        end
        resp_ready = 1'b1;
        if (hold > 0) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || (wr_count - base) !== int'(exp_we) ||
            csr_mem[addr] !== (exp_we ? exp_new : init)) begin
            errors++; $display("FAIL %s done: rv=%b rr=%b writes=%0d mem=%h required 0 1 %0d %h",
                               tag, resp_valid, req_ready, wr_count - base, csr_mem[addr],
                               exp_we, exp_we ? exp_new : init);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_during");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_after");
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        run_req(2'b01, 1'b0, 12'h300, 32'hDEADBEEF, 5'd1, 3'd1, 32'h11, 0, "rw_300");
        run_req(2'b10, 1'b1, 12'h340, 32'hFFFF_FFFF, 5'h05, 3'd2, 32'hA0, 0, "rs_imm");
        run_req(2'b11, 1'b0, 12'h340, 32'hF0, 5'd7, 3'd3, 32'hA5, 0, "rc_rs1");
        run_req(2'b10, 1'b0, 12'hC00, 32'hFFFF_FFFF, 5'd0, 3'd4, 32'h1234, 0, "rs_ro_read");
        run_req(2'b01, 1'b0, 12'hC00, 32'h5555_AAAA, 5'd9, 3'd5, 32'h1234, 0, "rw_ro_illegal");
        run_req(2'b00, 1'b0, 12'h300, 32'h1, 5'd3, 3'd6, 32'h42, 0, "op_reserved");
        run_req(2'b11, 1'b1, 12'h305, 32'h0, 5'd0, 3'd7, 32'hFFFF, 0, "rc_zimm0");
    endtask

    task automatic test_backpressure();
        run_req(2'b01, 1'b0, 12'h341, 32'hCAFEF00D, 5'd2, 3'd5, 32'h0BAD, 5, "backpressure");
    endtask

    task automatic test_flush();
        int base;
        set_csr(12'h305, 32'h77);
        req_valid = 1'b1; req_op = 2'b01; req_use_imm = 1'b0; req_addr = 12'h305;
        req_rs1_data = 32'h55; req_zimm = 5'd3; req_ticket = 3'd2; resp_ready = 1'b1;
        base = wr_count;
        @(posedge clk); #1;                       // READ
        req_valid = 1'b0;
        @(posedge clk); #1;                       // WRITE
        flush = 1'b1;
        #1;
        checks++;
        if (csr_wr_en !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL flush_write: we=%b rr=%b required 0 0", csr_wr_en, req_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || wr_count !== base || csr_mem[12'h305] !== 32'h77) begin
            errors++; $display("FAIL flush_after: rv=%b rr=%b writes=%0d mem=%h required 0 1 0 77",
                               resp_valid, req_ready, wr_count - base, csr_mem[12'h305]);
        end
        run_req(2'b01, 1'b0, 12'h305, 32'h55, 5'd3, 3'd3, 32'h77, 0, "after_flush");
    endtask

    task automatic test_reset_mid();
        int base;
        set_csr(12'h301, 32'h99);
        req_valid = 1'b1; req_op = 2'b01; req_use_imm = 1'b0; req_addr = 12'h301;
        req_rs1_data = 32'h1; req_zimm = 5'd4; req_ticket = 3'd6; resp_ready = 1'b1;
        base = wr_count;
        @(posedge clk); #1;                       // READ
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_count !== base || csr_mem[12'h301] !== 32'h99 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_discard: writes=%0d mem=%h rv=%b required 0 99 0",
                               wr_count - base, csr_mem[12'h301], resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int hs[3];
        int n = 0;
        int base;
        set_csr(12'h342, 32'h0);
        req_valid = 1'b1; req_op = 2'b01; req_use_imm = 1'b0; req_addr = 12'h342;
        req_rs1_data = 32'h1357_9BDF; req_zimm = 5'd8; req_ticket = 3'd1; resp_ready = 1'b1;
        base = wr_count;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (req_valid && req_ready) begin hs[n] = i; n++; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d handshakes required 3", n);
        end else begin
            checks++;
            if (hs[1] - hs[0] !== 4 || hs[2] - hs[1] !== 4) begin
                errors++; $display("FAIL b2b_spacing: got %0d,%0d required 4,4", hs[1] - hs[0], hs[2] - hs[1]);
            end
        end
        checks++;
        if (wr_count - base !== 3 || csr_mem[12'h342] !== 32'h1357_9BDF) begin
            errors++; $display("FAIL b2b_writes: got %0d mem=%h required 3 13579bdf",
                               wr_count - base, csr_mem[12'h342]);
        end
    endtask

    task automatic test_random();
        logic [11:0] addr;
        logic [4:0]  zimm;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 12'h300;
                1:       addr = 12'hC00;
                2:       addr = {2'b11, 10'($urandom)};
                default: addr = 12'($urandom);
            endcase
            zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_req(2'($urandom), 1'($urandom), addr, $urandom, zimm, 3'($urandom),
                    $urandom, $urandom_range(0, 2), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
